// File: rtl/axi_data_downconverter.sv
// axi_data_downconverter: 64-bit AXI-Stream with tkeep to 32-bit AXI-Stream with tlast
module axi_data_downconverter #(
  parameter int ERR_WIDTH      = 16,
  parameter bit LOW_WORD_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [63:0]          sAxisTdata,
  input  logic [7:0]           sAxisTkeep,
  input  logic                 sAxisTlast,
  input  logic                 sAxisTvalid,
  output logic                 sAxisTready,
  output logic [31:0]          mAxisTdata,
  output logic                 mAxisTlast,
  output logic                 mAxisTvalid,
  input  logic                 mAxisTready,
  output logic [ERR_WIDTH-1:0] errorCount
);
  typedef enum logic [1:0] {EMPTY, FIRST, SECOND} state_t;
  state_t state, state_nx;
  logic [31:0] hf, hs, f_half, s_half;
  logic [3:0] f_keep, s_keep;
  logic hv1, hlast, final_word, done, acc, bad;
  assign f_half = LOW_WORD_FIRST ? sAxisTdata[31:0] : sAxisTdata[63:32];
  assign s_half = LOW_WORD_FIRST ? sAxisTdata[63:32] : sAxisTdata[31:0];
  assign f_keep = LOW_WORD_FIRST ? sAxisTkeep[3:0] : sAxisTkeep[7:4];
  assign s_keep = LOW_WORD_FIRST ? sAxisTkeep[7:4] : sAxisTkeep[3:0];
  // handshake, next state and output mux; a finished beat frees the input the same cycle
  always_comb begin
    final_word  = (state == SECOND) | ((state == FIRST) & ~hv1);
    done        = final_word & mAxisTready;
    sAxisTready = ~reset & ((state == EMPTY) | done);
    acc         = sAxisTvalid & sAxisTready;
    bad         = ~((f_keep == 4'hF) & ((s_keep == 4'h0) | (s_keep == 4'hF)));
    state_nx    = acc ? (|f_keep ? FIRST : |s_keep ? SECOND : EMPTY) :
                  done ? EMPTY :
                  ((state == FIRST) & mAxisTready) ? SECOND : state;
    mAxisTvalid = state != EMPTY;
    mAxisTlast  = hlast & final_word;
    mAxisTdata  = (state == SECOND) ? hs : hf;
  end
  // held beat, state and saturating keep-error counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      hf         <= '0;
      hs         <= '0;
      hv1        <= 1'b0;
      hlast      <= 1'b0;
      errorCount <= '0;
    end else begin
      state <= state_nx;
      if (acc) begin
        hf    <= f_half;
        hs    <= s_half;
        hv1   <= |s_keep;
        hlast <= sAxisTlast;
      end
      if (acc & bad & ~&errorCount) errorCount <= errorCount + ERR_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_axi_data_downconverter.sv
// tb_axi_data_downconverter: directed checks of the 64-to-32 stream downconverter
module tb_axi_data_downconverter;
  logic clk = 1'b0;
  logic reset;
  logic [63:0] s_tdata;
  logic [7:0] s_tkeep;
  logic s_tlast, s_tvalid, s_tready;
  logic [31:0] m_tdata;
  logic m_tlast, m_tvalid, m_tready;
  logic [3:0] err;
  logic acc;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  axi_data_downconverter #(.ERR_WIDTH(4), .LOW_WORD_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset),
    .sAxisTdata(s_tdata), .sAxisTkeep(s_tkeep), .sAxisTlast(s_tlast),
    .sAxisTvalid(s_tvalid), .sAxisTready(s_tready),
    .mAxisTdata(m_tdata), .mAxisTlast(m_tlast), .mAxisTvalid(m_tvalid),
    .mAxisTready(m_tready), .errorCount(err)
  );
  task automatic cyc();
    acc = s_tready & s_tvalid;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [63:0] d, input logic [7:0] k, input logic l);
    s_tvalid = v;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    m_tready = 1'b1;
    drive(1'b0, 64'h0, 8'h0, 1'b0);
    cyc();
    cyc();
    total++;
    if (s_tready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", s_tready); end
    total++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 32'h0 || err !== 4'h0) begin
      bad++; $display("FAIL reset_outs got v=%b l=%b d=%h e=%h want 0 0 0 0", m_tvalid, m_tlast, m_tdata, err);
    end
    reset = 1'b0;
    #1;
    total++;
    if (s_tready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b want=1", s_tready); end
  endtask
  task automatic test_full_beats();
    logic [63:0] beats [3];
    int bi;
    beats[0] = {32'd1, 32'd0};
    beats[1] = {32'd3, 32'd2};
    beats[2] = {32'd5, 32'd4};
    bi = 0;
    drive(1'b1, beats[0], 8'hFF, 1'b0);
    cyc();
    total++;
    if (acc !== 1'b1) begin bad++; $display("FAIL full_first_accept got=%b want=1", acc); end
    bi = 1;
    drive(1'b1, beats[1], 8'hFF, 1'b0);
    for (int k = 0; k < 6; k++) begin
      total++;
      if (m_tvalid !== 1'b1 || m_tdata !== 32'(k) || m_tlast !== (k == 5)) begin
        bad++; $display("FAIL full_word%0d got v=%b d=%h l=%b want v=1 d=%h l=%b", k, m_tvalid, m_tdata, m_tlast, k, k == 5);
      end
      cyc();
      if (acc) begin
        bi++;
        if (bi < 3) drive(1'b1, beats[bi], 8'hFF, bi == 2);
        else drive(1'b0, 64'h0, 8'h0, 1'b0);
      end
    end
    total++;
    if (m_tvalid !== 1'b0 || err !== 4'h0) begin
      bad++; $display("FAIL full_drain got v=%b e=%h want v=0 e=0", m_tvalid, err);
    end
  endtask
  task automatic test_half_beat();
    drive(1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 1'b1);
    cyc();
    drive(1'b1, {32'h2222_2222, 32'h1111_1111}, 8'hFF, 1'b0);
    total++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'hCCCC_DDDD || m_tlast !== 1'b1 || s_tready !== 1'b1) begin
      bad++; $display("FAIL half_word got v=%b d=%h l=%b r=%b want 1 ccccdddd 1 1", m_tvalid, m_tdata, m_tlast, s_tready);
    end
    cyc();
    drive(1'b0, 64'h0, 8'h0, 1'b0);
    total++;
    if (acc !== 1'b1 || m_tdata !== 32'h1111_1111 || m_tlast !== 1'b0) begin
      bad++; $display("FAIL half_next got acc=%b d=%h l=%b want 1 11111111 0", acc, m_tdata, m_tlast);
    end
    cyc();
    total++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'h2222_2222) begin
      bad++; $display("FAIL half_next_hi got v=%b d=%h want 1 22222222", m_tvalid, m_tdata);
    end
    cyc();
  endtask
  task automatic test_backpressure();
    drive(1'b1, {32'hB1B1_B1B1, 32'hB0B0_B0B0}, 8'hFF, 1'b1);
    m_tready = 1'b1;
    cyc();
    drive(1'b1, {32'hD1D1_D1D1, 32'hD0D0_D0D0}, 8'hFF, 1'b0);
    total++;
    if (m_tdata !== 32'hB0B0_B0B0 || m_tlast !== 1'b0 || s_tready !== 1'b0) begin
      bad++; $display("FAIL bp_word0 got d=%h l=%b r=%b want b0b0b0b0 0 0", m_tdata, m_tlast, s_tready);
    end
    cyc();
    m_tready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      total++;
      if (m_tvalid !== 1'b1 || m_tdata !== 32'hB1B1_B1B1 || m_tlast !== 1'b1 || s_tready !== 1'b0) begin
        bad++; $display("FAIL bp_stall%0d got v=%b d=%h l=%b r=%b want 1 b1b1b1b1 1 0", k, m_tvalid, m_tdata, m_tlast, s_tready);
      end
      cyc();
    end
    m_tready = 1'b1;
    #1;
    total++;
    if (m_tdata !== 32'hB1B1_B1B1 || s_tready !== 1'b1) begin
      bad++; $display("FAIL bp_release got d=%h r=%b want b1b1b1b1 1", m_tdata, s_tready);
    end
    cyc();
    drive(1'b0, 64'h0, 8'h0, 1'b0);
    total++;
    if (acc !== 1'b1 || m_tdata !== 32'hD0D0_D0D0) begin
      bad++; $display("FAIL bp_next got acc=%b d=%h want 1 d0d0d0d0", acc, m_tdata);
    end
    cyc();
    cyc();
  endtask
  task automatic test_keep_errors();
    drive(1'b1, {32'h4141_4141, 32'h4040_4040}, 8'h00, 1'b1);
    cyc();
    drive(1'b1, {32'h5151_5151, 32'h5050_5050}, 8'h07, 1'b1);
    total++;
    if (acc !== 1'b1 || m_tvalid !== 1'b0 || err !== 4'd1) begin
      bad++; $display("FAIL err_drop got acc=%b v=%b e=%0d want 1 0 1", acc, m_tvalid, err);
    end
    cyc();
    drive(1'b1, {32'h6161_6161, 32'h6060_6060}, 8'hF0, 1'b1);
    total++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'h5050_5050 || m_tlast !== 1'b1) begin
      bad++; $display("FAIL err_07 got v=%b d=%h l=%b want 1 50505050 1", m_tvalid, m_tdata, m_tlast);
    end
    cyc();
    drive(1'b0, 64'h0, 8'h0, 1'b0);
    total++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'h6161_6161 || m_tlast !== 1'b1 || err !== 4'd3) begin
      bad++; $display("FAIL err_f0 got v=%b d=%h l=%b e=%0d want 1 61616161 1 3", m_tvalid, m_tdata, m_tlast, err);
    end
    cyc();
  endtask
  task automatic test_saturate();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    drive(1'b1, 64'h0, 8'h00, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      cyc();
      if (k == 14) begin
        total++;
        if (err !== 4'd14) begin bad++; $display("FAIL sat_14 got=%0d want=14", err); end
      end
      if (k == 16 || k == 17) begin
        total++;
        if (err !== 4'hF) begin bad++; $display("FAIL sat_%0d got=%h want=f", k, err); end
      end
    end
    drive(1'b0, 64'h0, 8'h0, 1'b0);
    cyc();
  endtask
  task automatic test_reset_mid();
    drive(1'b1, {32'hA1A1_A1A1, 32'hA0A0_A0A0}, 8'hFF, 1'b1);
    m_tready = 1'b1;
    cyc();
    drive(1'b0, 64'h0, 8'h0, 1'b0);
    cyc();
    m_tready = 1'b0;
    total++;
    if (m_tdata !== 32'hA1A1_A1A1 || m_tlast !== 1'b1) begin
      bad++; $display("FAIL mid_second got d=%h l=%b want a1a1a1a1 1", m_tdata, m_tlast);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    m_tready = 1'b1;
    total++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || err !== 4'h0) begin
      bad++; $display("FAIL mid_reset got v=%b l=%b e=%h want 0 0 0", m_tvalid, m_tlast, err);
    end
    drive(1'b1, {32'd8, 32'd7}, 8'hFF, 1'b1);
    cyc();
    drive(1'b0, 64'h0, 8'h0, 1'b0);
    total++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'd7 || m_tlast !== 1'b0) begin
      bad++; $display("FAIL mid_word7 got v=%b d=%h l=%b want 1 7 0", m_tvalid, m_tdata, m_tlast);
    end
    cyc();
    total++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'd8 || m_tlast !== 1'b1) begin
      bad++; $display("FAIL mid_word8 got v=%b d=%h l=%b want 1 8 1", m_tvalid, m_tdata, m_tlast);
    end
    cyc();
    total++;
    if (m_tvalid !== 1'b0) begin bad++; $display("FAIL mid_drain got v=%b want 0", m_tvalid); end
  endtask
  initial begin
    test_reset();
    test_full_beats();
    test_half_beat();
    test_backpressure();
    test_keep_errors();
    test_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_data_downconverter.md
Name: axi_data_downconverter

Overview:
- Converts a 64-bit AXI-Stream with tkeep into a 32-bit AXI-Stream with tlast, in a single clock domain.
- It is the receive-side counterpart of the 32→64 upconverter chain. It sits between the 64-bit link/user interface and 32-bit consumers.
- Lower half is emitted first.
- Sustains one 32-bit output per clock when both halves are valid and the sink is always ready.

Parameters:
- ERR_WIDTH, 16, width of the saturating keep-error counter.
- LOW_WORD_FIRST, 1, 1: emit tdata[31:0] before tdata[63:32]; 0: reverse order (keep nibbles swap roles accordingly).

Ports:
- clk  input  1  single clock for all logic.
- reset  input  1  synchronous, active-high reset.
- sAxisTdata  input  64  input beat data.
- sAxisTkeep  input  8  byte enables; bits [3:0] cover tdata[31:0], bits [7:4] cover tdata[63:32].
- sAxisTlast  input  1  last beat of packet.
- sAxisTvalid  input  1  input beat valid.
- sAxisTready  output  1  block can accept an input beat.
- mAxisTdata  output  32  output word.
- mAxisTlast  output  1  last word of packet.
- mAxisTvalid  output  1  output word valid.
- mAxisTready  input  1  sink accepts word.
- errorCount  output  ERR_WIDTH  saturating count of beats whose tkeep is not 8'h0F/8'hFF (8'hF0/8'hFF when LOW_WORD_FIRST=0).

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset values: sAxisTready=0 during reset and 1 the cycle after; mAxisTvalid=0; mAxisTlast=0; mAxisTdata=0; errorCount=0; state=EMPTY.
- Held beat register: data[63:0], plus half-valid flags hv0 and hv1 (first/second in emit order), plus last.
  - hv0 = |keep nibble of the first half.
  - hv1 = |keep nibble of the second half.
- States:
  - EMPTY: nothing held; mAxisTvalid=0.
  - FIRST: presenting the first-order half.
  - SECOND: presenting the second-order half.
- sAxisTready = (state==EMPTY) | (mAxisTready & mAxisTvalid & no further half pending after the current word). This allows back-to-back beats with no bubble.
- On an accepted beat (sAxisTvalid & sAxisTready):
  - hv0=1: next state FIRST; output = first half.
  - hv0=0 & hv1=1: next state SECOND; output = second half.
  - hv0=0 & hv1=0 (keep==0): beat dropped; state EMPTY unless a concurrent beat is pending; errorCount increments. A dropped beat's tlast is lost and is not back-annotated.
- Output timing: outputs are registered. A beat accepted in cycle N drives mAxisTvalid in cycle N+1.
- FIRST & mAxisTready:
  - hv1=1: go to SECOND.
  - hv1=0: the beat is done; load a new beat if one is offered, else go to EMPTY.
- SECOND & mAxisTready: the beat is done; load a new beat or go to EMPTY.
- mAxisTlast = held last & (current word is the final emitted half of the beat).
- mAxisTvalid=1 & mAxisTready=0: mAxisTdata/mAxisTlast/mAxisTvalid are held stable (AXI rule). Input is not accepted.
- Partial keep inside a nibble (e.g. 8'h07): the half is still emitted in full; errorCount increments once per beat.
- errorCount saturates at all-ones and does not wrap. Simultaneous error and reset: reset wins.
- Reset mid-packet: the held beat is discarded and no tlast is emitted. The next cycle is EMPTY.
- Throughput:
  - Full beats: 2 output words per input beat, 100% output utilisation.
  - Single-half beats: 1 word per beat, no bubbles.

Test Plan:
- Reset then 3 beats keep=FF, data {1,0},{3,2},{5,4}, last on the 3rd, sink always ready -> words 0,1,2,3,4,5 on 6 consecutive cycles starting 1 cycle after the first accept; tlast only on word 5; errorCount=0.
- Beat keep=0F data 64'hAAAA_BBBB_CCCC_DDDD with last -> single word 32'hCCCC_DDDD with tlast; next beat accepted the same cycle that word transfers.
- Sink backpressure (mAxisTready toggling 1,0,0,1) on a keep=FF beat -> each word held stable while stalled; sAxisTready stays 0 until the second word transfers.
- Beats keep=00, 07, F0 -> first beat dropped (no output); 07 emits the low word; F0 emits the high word; errorCount=3.
- errorCount preset to all-ones by a forced run of 2^ERR_WIDTH bad beats (ERR_WIDTH=4: 16 beats) -> stays 4'hF after the 17th bad beat.
- Assert reset while in SECOND state with mAxisTready=0 -> next cycle mAxisTvalid=0 and errorCount=0; following packet {8,7} keep=FF last -> words 7,8, tlast on 8.
